// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared tap count, default high-pass kernel and width helpers for conv3x3_stream
package conv_pkg;

    localparam int TAPS = 9;

    // Row-major, index 0 = top-left.
    localparam int HPF_KERNEL [TAPS] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + coef_w + 1;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w);
        return prod_w(data_w, coef_w) + 4;
    endfunction

    function automatic int round_bias(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// rtl/conv_adder_tree.sv - 4-stage pipelined signed adder tree 9->5->3->2->1 with stall enable and per-stage valids
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int ACC_W = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic [TAPS*IN_W-1:0]     i_terms,
    output logic                     o_valid,
    output logic signed [ACC_W-1:0]  o_sum
);

    logic signed [ACC_W-1:0] w_term [TAPS];

    for (genvar k = 0; k < TAPS; k++) begin : g_ext
        assign w_term[k] = {{(ACC_W-IN_W){i_terms[IN_W*(k+1)-1]}}, i_terms[IN_W*k +: IN_W]};
    end

    logic signed [ACC_W-1:0] r_s2 [5];
    logic signed [ACC_W-1:0] r_s3 [3];
    logic signed [ACC_W-1:0] r_s4 [2];
    logic signed [ACC_W-1:0] r_s5;
    logic [3:0]              r_v;

    // The odd term of each level is carried forward unchanged to stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v <= '0;
            for (int i = 0; i < 5; i++) r_s2[i] <= '0;
            for (int i = 0; i < 3; i++) r_s3[i] <= '0;
            for (int i = 0; i < 2; i++) r_s4[i] <= '0;
            r_s5 <= '0;
        end else if (i_en) begin
            r_v <= {r_v[2:0], i_valid};
            for (int i = 0; i < 4; i++) r_s2[i] <= w_term[2*i] + w_term[2*i+1];
            r_s2[4] <= w_term[8];
            r_s3[0] <= r_s2[0] + r_s2[1];
            r_s3[1] <= r_s2[2] + r_s2[3];
            r_s3[2] <= r_s2[4];
            r_s4[0] <= r_s3[0] + r_s3[1];
            r_s4[1] <= r_s3[2];
            r_s5    <= r_s4[0] + r_s4[1];
        end
    end

    assign o_valid = r_v[3];
    assign o_sum   = r_s5;

endmodule

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - 3x3 window times runtime signed kernel, pipelined sum, shift and unsigned saturation
// Optional round-half-up before the shift when CONV_ROUND_EN is defined.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 9,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [TAPS*DATA_WIDTH-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_sat,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_addr,
    input  logic [COEF_WIDTH-1:0]      cfg_data,
    input  logic                       cfg_commit
);

    localparam int PROD_W = prod_w(DATA_WIDTH, COEF_WIDTH);
    localparam int ACC_W  = acc_w(DATA_WIDTH, COEF_WIDTH);
    localparam int RES_W  = ACC_W + 1;

    logic signed [COEF_WIDTH-1:0] r_shadow [TAPS];
    logic signed [COEF_WIDTH-1:0] r_active [TAPS];
    logic [TAPS*PROD_W-1:0]       r_prod;
    logic                         r_s1_valid;
    logic                         w_en;
    logic                         w_tree_valid;
    logic signed [ACC_W-1:0]      w_sum;
    logic signed [PROD_W-1:0]     w_prod [TAPS];

    assign w_en    = !w_tree_valid || m_ready;
    assign s_ready = w_en;
    assign m_valid = w_tree_valid;

    // A write landing in the commit cycle bypasses the shadow straight into the active bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_shadow[k] <= COEF_WIDTH'(HPF_KERNEL[k]);
                r_active[k] <= COEF_WIDTH'(HPF_KERNEL[k]);
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (cfg_we && cfg_addr == 4'(k)) r_shadow[k] <= cfg_data;
                if (cfg_commit) r_active[k] <= (cfg_we && cfg_addr == 4'(k)) ? cfg_data : r_shadow[k];
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_mul
        logic signed [PROD_W-1:0] w_pix_ext;
        logic signed [PROD_W-1:0] w_coef_ext;
        assign w_pix_ext  = {{(PROD_W-DATA_WIDTH){1'b0}}, s_data[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]};
        assign w_coef_ext = {{(PROD_W-COEF_WIDTH){r_active[k][COEF_WIDTH-1]}}, r_active[k]};
        assign w_prod[k]  = w_pix_ext * w_coef_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_prod     <= '0;
        end else if (w_en) begin
            r_s1_valid <= s_valid;
            for (int k = 0; k < TAPS; k++) r_prod[k*PROD_W +: PROD_W] <= w_prod[k];
        end
    end

    conv_adder_tree #(
        .IN_W  (PROD_W),
        .ACC_W (ACC_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_valid (r_s1_valid),
        .i_terms (r_prod),
        .o_valid (w_tree_valid),
        .o_sum   (w_sum)
    );

    localparam logic signed [RES_W-1:0] PIX_MAX = RES_W'((1 << DATA_WIDTH) - 1);
`ifdef CONV_ROUND_EN
    localparam logic signed [RES_W-1:0] ROUND_ADD = RES_W'(round_bias(OUT_SHIFT));
`else
    localparam logic signed [RES_W-1:0] ROUND_ADD = '0;
`endif

    logic signed [RES_W-1:0] w_biased;
    logic signed [RES_W-1:0] w_res;

    // One extra bit keeps the rounding add from wrapping.
    assign w_biased = {w_sum[ACC_W-1], w_sum} + ROUND_ADD;
    assign w_res    = w_biased >>> OUT_SHIFT;

    always_comb begin
        m_data = w_res[DATA_WIDTH-1:0];
        m_sat  = 1'b0;
        if (w_res[RES_W-1]) begin
            m_data = '0;
            m_sat  = 1'b1;
        end else if (w_res > PIX_MAX) begin
            m_data = '1;
            m_sat  = 1'b1;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - scoreboard bench for conv3x3_stream at OUT_SHIFT 0 and 3 with shared stimulus
module tb_conv3x3_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [71:0] s_data = '0;
    logic        m_ready = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [8:0]  cfg_data = '0;
    logic        cfg_commit = 1'b0;

    logic       s_ready0, m_valid0, m_sat0;
    logic [7:0] m_data0;
    logic       s_ready3, m_valid3, m_sat3;
    logic [7:0] m_data3;

    int checks = 0;
    int errors = 0;

`ifdef CONV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic [8:0] q0 [$];
    logic [8:0] q3 [$];
    bit         rand_mode = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] held_data;
    logic       held_sat;
    int         hpf [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

    conv3x3_stream #(.DATA_WIDTH(8), .COEF_WIDTH(9), .OUT_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_sat(m_sat0),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit)
    );

    conv3x3_stream #(.DATA_WIDTH(8), .COEF_WIDTH(9), .OUT_SHIFT(3)) u_dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
        .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3), .m_sat(m_sat3),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rand_mode) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name, inout logic [8:0] q [$], input logic sat, input logic [7:0] d);
        logic [8:0] e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got data %0d sat %0d with nothing expected", name, d, sat);
        end else begin
            e = q.pop_front();
            checks++;
            if ({sat, d} !== e) begin
                errors++;
                $display("FAIL %s: got data %0d sat %0d expected data %0d sat %0d", name, d, sat, e[7:0], e[8]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(m_valid0 && m_data0 === held_data && m_sat0 === held_sat)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %0d data %0d expected valid 1 data %0d", m_valid0, m_data0, held_data);
                end
            end
            if (m_valid0 && m_ready) pop_cmp("out_shift0", q0, m_sat0, m_data0);
            if (m_valid3 && m_ready) pop_cmp("out_shift3", q3, m_sat3, m_data3);
            stall_prev = m_valid0 && !m_ready;
            held_data  = m_data0;
            held_sat   = m_sat0;
        end
    end

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = v;
        return w;
    endfunction

    function automatic logic [8:0] model(input logic [71:0] w, input int kern [9], input int sh);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[8*k +: 8]) * kern[k];
        if (RND && sh > 0) s += 1 << (sh - 1);
        s = s >>> sh;
        if (s < 0) return {1'b1, 8'd0};
        if (s > 255) return {1'b1, 8'hff};
        return {1'b0, 8'(s)};
    endfunction

    task automatic send(input logic [71:0] w, input logic [8:0] e0, input logic [8:0] e3);
        logic rdy = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rdy = s_ready0;
            @(posedge clk);
            if (rdy) break;
        end
        if (rdy) begin
            q0.push_back(e0);
            q3.push_back(e3);
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready 0 expected 1");
        end
        #1;
        s_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [8:0] d, input bit commit);
        cfg_we     = 1'b1;
        cfg_addr   = a;
        cfg_data   = d;
        cfg_commit = commit;
        @(posedge clk);
        #1;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400; n++) begin
            if (q0.size() == 0 && q3.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_pending", q0.size() + q3.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] w;
        int seen;

        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid0, 0);
        check("rst_m_data", m_data0, 0);
        check("rst_m_sat", m_sat3, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst", s_ready0, 1);
        @(posedge clk);
        #1;

        // All taps 100 under the HPF kernel, with latency measured.
        s_data  = fill(8'd100);
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        q0.push_back({1'b0, 8'd100});
        q3.push_back({1'b0, RND ? 8'd13 : 8'd12});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("latency_early", m_valid0, 0);
        @(posedge clk);
        @(negedge clk);
        check("latency_5", m_valid0, 1);
        @(posedge clk);
        #1;

        w = '0; w[39:32] = 8'd255;
        send(w, {1'b1, 8'd255}, {1'b0, 8'd159});
        w = fill(8'd255); w[39:32] = 8'd0;
        send(w, {1'b1, 8'd0}, {1'b1, 8'd0});
        wait_drain();

        rand_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'((i*37 + k*53 + i*k*11) % 256);
            send(w, model(w, hpf, 0), model(w, hpf, 3));
        end
        wait_drain();
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;

        // All-ones kernel; last write, commit and window A share one cycle.
        for (int k = 0; k < 8; k++) cfg_write(4'(k), 9'd1, 1'b0);
        cfg_we = 1'b1; cfg_addr = 4'd8; cfg_data = 9'd1; cfg_commit = 1'b1;
        send(fill(8'd8), {1'b0, 8'd8}, {1'b0, 8'd1});
        cfg_we = 1'b0; cfg_commit = 1'b0;
        send(fill(8'd8), {1'b0, 8'd72}, {1'b0, 8'd9});

        cfg_write(4'd9, 9'd0, 1'b0);
        cfg_write(4'd12, 9'd0, 1'b0);
        cfg_write(4'd15, 9'd0, 1'b1);
        send(fill(8'd8), {1'b0, 8'd72}, {1'b0, 8'd9});

        send(72'd76, {1'b0, 8'd76}, {1'b0, RND ? 8'd10 : 8'd9});
        send(72'd255, {1'b0, 8'd255}, {1'b0, RND ? 8'd32 : 8'd31});
        send(72'h01ff, {1'b1, 8'd255}, {1'b0, 8'd32});
        wait_drain();

        // Mid-stream reset with a pending shadow write.
        cfg_write(4'd4, 9'd0, 1'b0);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(fill(8'd8), {1'b0, 8'd72}, {1'b0, 8'd9});
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m_valid0) break;
        end
        check("inflight_valid", m_valid0, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", m_valid0, 0);
        check("async_rst_data", m_data0, 0);
        check("async_rst_sat", m_sat0, 0);
        q0.delete();
        q3.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst2", s_ready0, 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid0) seen++;
        end
        check("no_stale_output", seen, 0);
        @(posedge clk);
        #1;
        send(fill(8'd100), {1'b0, 8'd100}, {1'b0, RND ? 8'd13 : 8'd12});
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        send(fill(8'd100), {1'b0, 8'd100}, {1'b0, RND ? 8'd13 : 8'd12});
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
